stream_arbiter_qos_rr: RTL
==========================

# stream_arbiter_qos_rr

Packet-granular N-to-1 stream arbiter with QoS priority, round-robin tie-breaking and starvation aging. It is the parametrised successor of the two-stream QoS arbiter and sits between the per-source stream FIFOs and the shared egress link. Arbitration happens once per packet, and a granted stream is locked until its `last` beat is accepted. A single registered output stage gives latency 1 with full back-pressure support.

## Interface
Parameters:
- `T_DATA_WIDTH`, 8: data width per beat.
- `T_QOS__WIDTH`, 4: QoS field width; larger value = higher priority.
- `STREAM_COUNT`, 4: number of input streams; legal range 2..16.
- `MAX_WAIT`, 7: lost arbitrations before a stream is promoted to urgent. 0 disables aging.
- `T_ID___WIDTH`, `$clog2(STREAM_COUNT)`: width of `m_id_o`.

Ports:
- `clk_i` in 1: the block's only clock; everything is synchronous to it.
- `rst_i` in 1: reset, synchronous, active-high.
- `s_data_i` in `[T_DATA_WIDTH-1:0]` x `STREAM_COUNT`: input data.
- `s_qos_i` in `[T_QOS__WIDTH-1:0]` x `STREAM_COUNT`: input QoS.
- `s_last_i` in `STREAM_COUNT`: end-of-packet flag, per stream.
- `s_valid_i` in `STREAM_COUNT`: beat valid, per stream.
- `s_ready_o` out `STREAM_COUNT`: beat ready, per stream.
- `m_data_o` out `T_DATA_WIDTH`: output data.
- `m_qos_o` out `T_QOS__WIDTH`: QoS of the granted packet.
- `m_id_o` out `T_ID___WIDTH`: index of the granted stream.
- `m_last_o` out 1: end of packet.
- `m_valid_o` out 1: output valid.
- `m_ready_i` in 1: downstream ready.

## Operation
- Beat transfer: an input beat is accepted when `s_valid_i[k] & s_ready_o[k]`. An output beat completes when `m_valid_o & m_ready_i`.
- FSM has two states:
  - IDLE: all `s_ready_o` are 0. If any `s_valid_i` is high, run arbitration, register `grant`, `grant_qos` and `wait_cnt` updates, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: `s_ready_o[grant] = ~m_valid_o | m_ready_i`; all other ready bits are 0. When a beat with `s_last_i[grant]=1` is accepted, go to IDLE in the next cycle.
- Arbitration runs only in IDLE and considers only streams with `s_valid_i` high.
  - A stream is urgent when `MAX_WAIT != 0` and `wait_cnt[k] >= MAX_WAIT`.
  - Ranking: urgent beats non-urgent; then higher `s_qos_i` wins. QoS 0 is an ordinary lowest level.
  - Ties: first candidate scanning upward from `rr_ptr`, wrapping modulo `STREAM_COUNT`.
- `rr_ptr`: set to `(grant+1) mod STREAM_COUNT` at each arbitration.
- `wait_cnt[k]`: width `$clog2(MAX_WAIT+1)`, saturating at `MAX_WAIT`. At each arbitration event:
  - cleared if stream `k` is granted or `s_valid_i[k]` is 0;
  - incremented if `s_valid_i[k]` is 1 and `k` lost.
- Output register:
  - On an accepted input beat, load `m_data_o`, `m_last_o` from `s_*[grant]`, `m_id_o <= grant`, `m_qos_o <= grant_qos`, and set `m_valid_o`.
  - Otherwise, if `m_ready_i` is high, clear `m_valid_o`.
  - While `m_valid_o & ~m_ready_i`, all `m_*` outputs hold.
- Boundary conditions:
  - `s_qos_i` changes mid-packet are ignored; `m_qos_o` stays constant for the whole packet.
  - If `s_valid_i[grant]` drops mid-packet, the lock is kept: other streams wait, and `m_valid_o` falls once the last registered beat drains.
  - Simultaneous last-beat accept and new requests: new arbitration happens in the following IDLE cycle, never in the same cycle.
  - Out-of-range `grant` is impossible; `STREAM_COUNT` is not a power of two wraps correctly via modulo.

## Timing
- Reset (synchronous, `rst_i`=1 at a clock edge):
  - `m_valid_o`, `m_last_o`, `m_data_o`, `m_qos_o`, `m_id_o` = 0.
  - `s_ready_o` = 0, `state` = IDLE, `rr_ptr` = 0, all `wait_cnt` = 0.
- Reset mid-packet aborts the packet; no further beats of it are emitted.
- Latency: an input beat accepted at edge t is visible on `m_*` at t+1.
- Arbitration costs one IDLE cycle per packet. Peak throughput is L/(L+1) for L-beat packets; within a packet it is 1 beat/cycle.
- `s_ready_o` depends combinationally on `m_ready_i`, `state` and `grant`; there is no combinational path from `s_valid_i`.
- `m_*` outputs are purely registered.

## Test plan
- Stream qos {1,5,3,5}, all valid, 2-beat packets, `m_ready_i`=1 -> grant order 1, 3, 1, 3…:
  - streams 0 and 2 are starved until `MAX_WAIT`=7 losses;
  - then stream 2 is promoted (qos 3 > qos 1), and stream 0 in the next round.
- All qos equal, all valid, `MAX_WAIT`=0 -> grant order 0, 1, 2, 3, 0; `m_id_o` matches each packet; one idle cycle between packets.
- 4-beat packet on stream 2 with `m_ready_i` toggling 1,0,0,1… -> no beat lost or duplicated; `m_*` stable while stalled; `s_ready_o[2]` low when `m_valid_o & ~m_ready_i`.
- Stream 1 drops `s_valid_i` for 3 cycles mid-packet while stream 0 is valid at qos 15 -> stream 1 keeps the lock; stream 0 is granted only after stream 1's last beat.
- Change `s_qos_i[3]` from 2 to 9 after the first beat -> `m_qos_o`=2 for the whole packet.
- Assert `rst_i` in the middle of a packet -> next cycle all outputs 0, state IDLE; the next arbitration starts from `rr_ptr`=0.

Source files
------------

// File: rtl/stream_arbiter_qos_rr.sv
// Packet-granular N-to-1 stream arbiter: QoS priority, round-robin tie-break,
// starvation aging, one registered output stage with full back-pressure.
module stream_arbiter_qos_rr_wait #(
   parameter int MAX_WAIT = 7,
   parameter int WAIT_W   = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic arb_i,
   input  logic valid_i,
   input  logic win_i,
   output logic urgent_o
);
   logic [WAIT_W-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt <= '0;
      else if (arb_i) begin
         if (win_i || !valid_i) cnt <= '0;
         else if (cnt < WAIT_W'(MAX_WAIT)) cnt <= cnt + WAIT_W'(1);
      end
   end

   assign urgent_o = (MAX_WAIT != 0) && (cnt >= WAIT_W'(MAX_WAIT));
endmodule

module stream_arbiter_qos_rr #(
   parameter int T_DATA_WIDTH = 8,
   parameter int T_QOS__WIDTH = 4,
   parameter int STREAM_COUNT = 4,
   parameter int MAX_WAIT     = 7,
   parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
   input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
   input  logic [STREAM_COUNT-1:0]                   s_last_i,
   input  logic [STREAM_COUNT-1:0]                   s_valid_i,
   output logic [STREAM_COUNT-1:0]                   s_ready_o,
   output logic [T_DATA_WIDTH-1:0]                   m_data_o,
   output logic [T_QOS__WIDTH-1:0]                   m_qos_o,
   output logic [T_ID___WIDTH-1:0]                   m_id_o,
   output logic                                      m_last_o,
   output logic                                      m_valid_o,
   input  logic                                      m_ready_i
);
   localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nxt;

   logic [T_ID___WIDTH-1:0] grant, rr_ptr, arb_idx;
   logic [T_QOS__WIDTH-1:0] grant_qos;
   logic [STREAM_COUNT-1:0] urgent;
   logic                    arb, out_free, beat_acc, last_acc;

   assign arb      = (state == IDLE) && (|s_valid_i);
   assign out_free = ~m_valid_o | m_ready_i;
   assign beat_acc = (state == BUSY) && s_valid_i[grant] && out_free;
   assign last_acc = beat_acc && s_last_i[grant];

   // Rank key is {urgent, qos}; scanning from rr_ptr with a strict '>' keeps the first tie.
   always_comb begin
      logic [T_QOS__WIDTH:0]   best_key, key;
      logic [T_ID___WIDTH-1:0] sel;
      logic                    found;
      int                      idx;
      arb_idx  = '0;
      best_key = '0;
      key      = '0;
      sel      = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= STREAM_COUNT) idx = idx - STREAM_COUNT;
         sel = T_ID___WIDTH'(idx);
         key = {urgent[sel], s_qos_i[sel]};
         if (s_valid_i[sel] && (!found || key > best_key)) begin
            found    = 1'b1;
            best_key = key;
            arb_idx  = sel;
         end
      end
   end

   for (genvar k = 0; k < STREAM_COUNT; k++) begin : g_lane
      stream_arbiter_qos_rr_wait #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wait (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .arb_i    (arb),
         .valid_i  (s_valid_i[k]),
         .win_i    (arb_idx == T_ID___WIDTH'(k)),
         .urgent_o (urgent[k])
      );
      assign s_ready_o[k] = (state == BUSY) && (grant == T_ID___WIDTH'(k)) && out_free;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|s_valid_i) state_nxt = BUSY;
         BUSY:    if (last_acc)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grant     <= '0;
         grant_qos <= '0;
         rr_ptr    <= '0;
         m_data_o  <= '0;
         m_qos_o   <= '0;
         m_id_o    <= '0;
         m_last_o  <= 1'b0;
         m_valid_o <= 1'b0;
      end else begin
         if (arb) begin
            grant     <= arb_idx;
            grant_qos <= s_qos_i[arb_idx];
            rr_ptr    <= (arb_idx == T_ID___WIDTH'(STREAM_COUNT - 1)) ? '0
                                                                    : arb_idx + T_ID___WIDTH'(1);
         end
         // QoS is frozen at arbitration so mid-packet s_qos_i changes never reach m_qos_o.
         if (beat_acc) begin
            m_data_o  <= s_data_i[grant];
            m_last_o  <= s_last_i[grant];
            m_id_o    <= grant;
            m_qos_o   <= grant_qos;
            m_valid_o <= 1'b1;
         end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
         end
      end
   end
endmodule
